// File: rtl/load_store_unit_if.sv
// load_store_unit_if: byte-wide data memory port with wait-state handshake
// mem_addr/mem_wdata/mem_we/mem_re flow from the unit (master) to memory (slave);
// mem_rdata is the combinational read byte for mem_addr, mem_ready completes a byte transfer.
interface load_store_unit_if #(parameter int ADDR_W = 64);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0] mem_wdata;
   logic mem_we;
   logic mem_re;
   logic [7:0] mem_rdata;
   logic mem_ready;
   modport master(output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata, mem_ready);
   modport slave(input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata, mem_ready);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: splits one MEM-stage load/store into little-endian single-byte memory transfers
// Pipeline side: MemRead/MemWrite/address/writeData/size/sign_ext in; stall, readData, resp_valid, err out.
// Memory side: mem (load_store_unit_if.master) carries the byte address, write byte, strobes and ready.
module load_store_unit #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W = 64
) (
   input logic clk,
   input logic rst_n,
   input logic MemRead,
   input logic MemWrite,
   input logic [ADDR_W-1:0] address,
   input logic [63:0] writeData,
   input logic [1:0] size,
   input logic sign_ext,
   output logic stall,
   output logic [63:0] readData,
   output logic resp_valid,
   output logic err,
   load_store_unit_if.master mem
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state;
   logic [2:0] cnt, cnt_n, last;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0] wdata_q, rbuf, rbuf_n, ext;
   logic [1:0] size_q;
   logic sx_q, st_q, req, oob;
   assign req = MemRead | MemWrite;
   // one extra bit keeps address+nbytes from wrapping near the top of the address space
   assign oob = ({1'b0, address} + (ADDR_W+1)'(4'd1 << size)) > (ADDR_W+1)'(MEM_BYTES);
   // index of the final byte: nbytes-1 = 0,1,3,7
   assign last = {&size_q, size_q[1], |size_q};
   assign cnt_n = cnt + 3'd1;
   assign stall = (state == IDLE && req) || state == ACCESS;
   always_comb begin
      rbuf_n = rbuf;
      rbuf_n[{cnt, 3'b000} +: 8] = mem.mem_rdata;
   end
   assign ext = size_q == 2'd0 ? {{56{sx_q & rbuf_n[7]}}, rbuf_n[7:0]} :
                size_q == 2'd1 ? {{48{sx_q & rbuf_n[15]}}, rbuf_n[15:0]} :
                size_q == 2'd2 ? {{32{sx_q & rbuf_n[31]}}, rbuf_n[31:0]} : rbuf_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         readData <= '0;
         resp_valid <= 1'b0;
         err <= 1'b0;
         mem.mem_we <= 1'b0;
         mem.mem_re <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_wdata <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         size_q <= '0;
         sx_q <= 1'b0;
         st_q <= 1'b0;
         rbuf <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               addr_q <= address;
               wdata_q <= writeData;
               size_q <= size;
               sx_q <= sign_ext;
               st_q <= MemWrite;
               cnt <= '0;
               rbuf <= '0;
               if (oob) begin
                  state <= DONE;
                  err <= 1'b1;
                  resp_valid <= 1'b1;
                  readData <= '0;
               end else begin
                  state <= ACCESS;
                  mem.mem_addr <= address;
                  mem.mem_wdata <= writeData[7:0];
                  mem.mem_we <= MemWrite;
                  mem.mem_re <= !MemWrite;
               end
            end
            // outputs are registered, so each transfer preloads the next byte's address and data
            ACCESS: if (mem.mem_ready) begin
               rbuf <= rbuf_n;
               cnt <= cnt_n;
               if (cnt == last) begin
                  state <= DONE;
                  mem.mem_we <= 1'b0;
                  mem.mem_re <= 1'b0;
                  resp_valid <= 1'b1;
                  readData <= st_q ? '0 : ext;
               end else begin
                  mem.mem_addr <= addr_q + ADDR_W'(cnt_n);
                  mem.mem_wdata <= wdata_q[{cnt_n, 3'b000} +: 8];
               end
            end
            default: begin
               state <= IDLE;
               resp_valid <= 1'b0;
               err <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a byte-array memory
module tb_load_store_unit;
   localparam int MEM_BYTES = 1024;
   typedef struct { int cyc; logic [63:0] data; logic e; } exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic MemRead = 1'b0, MemWrite = 1'b0, sign_ext = 1'b0;
   logic [63:0] address = '0, writeData = '0;
   logic [1:0] size = '0;
   logic stall, resp_valid, err;
   logic [63:0] readData;
   logic [7:0] ram [MEM_BYTES];
   int compared = 0, mismatched = 0;
   exp_t exp_q[$];
   logic [63:0] tr_addr [40];
   logic [7:0] tr_wd [40];
   logic tr_we [40], tr_re [40], tr_st [40];
   load_store_unit_if #(.ADDR_W(64)) bus ();
   load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
      .writeData(writeData), .size(size), .sign_ext(sign_ext), .stall(stall), .readData(readData),
      .resp_valid(resp_valid), .err(err), .mem(bus));
   always #5 clk = ~clk;
   assign bus.mem_rdata = (bus.mem_addr < 64'(MEM_BYTES)) ? ram[bus.mem_addr[9:0]] : 8'h00;
   always @(posedge clk) if (bus.mem_we && bus.mem_ready) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;

   // drives one request in cycle 0, records a per-cycle trace, returns response cycle (-1 on timeout)
   task automatic run_access(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                             input logic [1:0] sz, input logic sx, input logic [31:0] wait_mask,
                             output int cyc, output logic [63:0] rd, output logic e);
      logic [31:0] m;
      m = wait_mask;
      cyc = -1;
      rd = '0;
      e = 1'b0;
      @(posedge clk); #1;
      MemWrite = wr; MemRead = !wr; address = a; writeData = wd; size = sz; sign_ext = sx;
      bus.mem_ready = !m[0];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         tr_addr[c] = bus.mem_addr; tr_wd[c] = bus.mem_wdata;
         tr_we[c] = bus.mem_we; tr_re[c] = bus.mem_re; tr_st[c] = stall;
         if (resp_valid) begin
            cyc = c; rd = readData; e = err;
            break;
         end
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0;
         m = m >> 1;
         bus.mem_ready = !m[0];
      end
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ready = 1'b1;
   endtask

   task automatic test_reset;
      bus.mem_ready = 1'b1;
      #2;
      compared++; if (readData !== 64'h0) begin mismatched++; $display("FAIL reset_readData: got %h want 0", readData); end
      compared++; if (resp_valid !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL reset_resp_err: got %b%b want 00", resp_valid, err); end
      compared++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin mismatched++; $display("FAIL reset_strobes: got we=%b re=%b want 0", bus.mem_we, bus.mem_re); end
      compared++; if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 8'h0) begin mismatched++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
      compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", stall); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_store_double;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      logic [63:0] wd = 64'h1122334455667788;
      exp_q.push_back('{9, 64'h0, 1'b0});
      run_access(1'b1, 64'h10, wd, 2'd3, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL st8_latency: got %0d want %0d", cyc, x.cyc); end
      compared++; if (rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL st8_resp: got %h err=%b want %h err=%b", rd, e, x.data, x.e); end
      for (int i = 0; i < 9; i++) begin
         compared++; if (tr_st[i] !== 1'b1) begin mismatched++; $display("FAIL st8_stall c%0d: got %b want 1", i, tr_st[i]); end
      end
      compared++; if (tr_st[9] !== 1'b0 || tr_we[0] !== 1'b0 || tr_we[9] !== 1'b0) begin mismatched++; $display("FAIL st8_edges: got stall9=%b we0=%b we9=%b want 000", tr_st[9], tr_we[0], tr_we[9]); end
      for (int i = 1; i <= 8; i++) begin
         compared++;
         if (tr_we[i] !== 1'b1 || tr_re[i] !== 1'b0 || tr_addr[i] !== 64'h10 + 64'(i - 1) || tr_wd[i] !== wd[8*(i-1) +: 8]) begin
            mismatched++; $display("FAIL st8_byte c%0d: got we=%b re=%b addr=%h data=%h want 1 0 %h %h", i, tr_we[i], tr_re[i], tr_addr[i], tr_wd[i], 64'h10 + 64'(i - 1), wd[8*(i-1) +: 8]);
         end
      end
   endtask

   task automatic test_load_double;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      exp_q.push_back('{9, 64'h1122334455667788, 1'b0});
      run_access(1'b0, 64'h10, 64'h0, 2'd3, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL ld8_latency: got %0d want %0d", cyc, x.cyc); end
      compared++; if (rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL ld8_data: got %h err=%b want %h err=%b", rd, e, x.data, x.e); end
      for (int i = 1; i <= 8; i++) begin
         compared++; if (tr_re[i] !== 1'b1 || tr_we[i] !== 1'b0 || tr_addr[i] !== 64'h10 + 64'(i - 1)) begin mismatched++; $display("FAIL ld8_strobe c%0d: got re=%b we=%b addr=%h want 1 0 %h", i, tr_re[i], tr_we[i], tr_addr[i], 64'h10 + 64'(i - 1)); end
      end
   endtask

   task automatic test_sign_ext;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      logic [63:0] la [5] = '{64'h17, 64'h17, 64'h16, 64'h14, 64'h14};
      logic [1:0] ls [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
      logic lx [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [63:0] ld [5] = '{64'hFFFFFFFFFFFFFF80, 64'h80, 64'hFFFFFFFFFFFF8022, 64'hFFFFFFFF80223344, 64'h80223344};
      int lc [5] = '{2, 2, 3, 5, 5};
      exp_q.push_back('{2, 64'h0, 1'b0});
      run_access(1'b1, 64'h17, 64'h80, 2'd0, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || rd !== x.data) begin mismatched++; $display("FAIL st1: got cyc=%0d data=%h want %0d %h", cyc, rd, x.cyc, x.data); end
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{lc[i], ld[i], 1'b0});
         run_access(1'b0, la[i], 64'h0, ls[i], lx[i], 32'h0, cyc, rd, e);
         x = exp_q.pop_front();
         compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL ext%0d_latency: got %0d want %0d", i, cyc, x.cyc); end
         compared++; if (rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL ext%0d_data: got %h err=%b want %h err=%b", i, rd, e, x.data, x.e); end
      end
   endtask

   task automatic test_range;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      exp_q.push_back('{1, 64'h0, 1'b1});
      run_access(1'b0, 64'h3FF, 64'h0, 2'd1, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL oob_3ff: got cyc=%0d data=%h err=%b want %0d %h %b", cyc, rd, e, x.cyc, x.data, x.e); end
      compared++; if (tr_re[0] !== 1'b0 || tr_re[1] !== 1'b0 || tr_we[1] !== 1'b0) begin mismatched++; $display("FAIL oob_strobes: got re0=%b re1=%b we1=%b want 000", tr_re[0], tr_re[1], tr_we[1]); end
      compared++; if (tr_st[0] !== 1'b1 || tr_st[1] !== 1'b0) begin mismatched++; $display("FAIL oob_stall: got %b%b want 10", tr_st[0], tr_st[1]); end
      exp_q.push_back('{1, 64'h0, 1'b1});
      run_access(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 2'd3, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || e !== x.e || tr_re[1] !== 1'b0) begin mismatched++; $display("FAIL oob_wrap: got cyc=%0d err=%b re=%b want %0d %b 0", cyc, e, tr_re[1], x.cyc, x.e); end
      exp_q.push_back('{3, 64'h0, 1'b0});
      run_access(1'b1, 64'h3FE, 64'hBEEF, 2'd1, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || e !== x.e) begin mismatched++; $display("FAIL st2_3fe: got cyc=%0d err=%b want %0d %b", cyc, e, x.cyc, x.e); end
      exp_q.push_back('{3, 64'hBEEF, 1'b0});
      run_access(1'b0, 64'h3FE, 64'h0, 2'd1, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL ld2_3fe: got cyc=%0d data=%h err=%b want %0d %h %b", cyc, rd, e, x.cyc, x.data, x.e); end
   endtask

   task automatic test_wait_states;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      exp_q.push_back('{5, 64'h0, 1'b0});
      run_access(1'b1, 64'h11, 64'h55443322, 2'd2, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL st4_latency: got %0d want %0d", cyc, x.cyc); end
      exp_q.push_back('{8, 64'h55443322, 1'b0});
      run_access(1'b0, 64'h11, 64'h0, 2'd2, 1'b0, 32'h1C, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL ws_latency: got %0d want %0d", cyc, x.cyc); end
      compared++; if (rd !== x.data || e !== x.e) begin mismatched++; $display("FAIL ws_data: got %h err=%b want %h %b", rd, e, x.data, x.e); end
      for (int i = 2; i <= 5; i++) begin
         compared++; if (tr_addr[i] !== 64'h12 || tr_re[i] !== 1'b1 || tr_st[i] !== 1'b1) begin mismatched++; $display("FAIL ws_hold c%0d: got addr=%h re=%b stall=%b want 12 1 1", i, tr_addr[i], tr_re[i], tr_st[i]); end
      end
      compared++; if (tr_addr[6] !== 64'h13 || tr_addr[7] !== 64'h14) begin mismatched++; $display("FAIL ws_resume: got %h %h want 13 14", tr_addr[6], tr_addr[7]); end
   endtask

   task automatic test_reset_mid;
      int cyc; logic [63:0] rd; logic e; exp_t x;
      exp_q.push_back('{9, 64'h0, 1'b0});
      run_access(1'b1, 64'h100, {8{8'hAA}}, 2'd3, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc) begin mismatched++; $display("FAIL pre_fill: got %0d want %0d", cyc, x.cyc); end
      @(posedge clk); #1;
      MemWrite = 1'b1; address = 64'h100; writeData = 64'h0102030405060708; size = 2'd3;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      compared++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h104) begin mismatched++; $display("FAIL mid_before: got we=%b addr=%h want 1 104", bus.mem_we, bus.mem_addr); end
      rst_n = 1'b0;
      #1;
      compared++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || stall !== 1'b0 || resp_valid !== 1'b0) begin mismatched++; $display("FAIL mid_async: got we=%b re=%b stall=%b rv=%b want 0000", bus.mem_we, bus.mem_re, stall, resp_valid); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         compared++; if (resp_valid !== 1'b0 || stall !== 1'b0 || bus.mem_we !== 1'b0) begin mismatched++; $display("FAIL mid_idle c%0d: got rv=%b stall=%b we=%b want 000", i, resp_valid, stall, bus.mem_we); end
      end
      exp_q.push_back('{9, 64'hAAAAAAAA05060708, 1'b0});
      run_access(1'b0, 64'h100, 64'h0, 2'd3, 1'b0, 32'h0, cyc, rd, e);
      x = exp_q.pop_front();
      compared++; if (cyc !== x.cyc || rd !== x.data) begin mismatched++; $display("FAIL mid_contents: got cyc=%0d data=%h want %0d %h", cyc, rd, x.cyc, x.data); end
   endtask

   initial begin
      test_reset;
      test_store_double;
      test_load_double;
      test_sign_ext;
      test_range;
      test_wait_states;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
